// File: rtl/config_loader.sv
// Configuration-memory write sequencer: turns a header plus N payload words
// into one-hot write strobes with per-target address formation.
module config_loader #(
    parameter int NURN_CNT_BIT_WIDTH      = 8,
    parameter int AXON_CNT_BIT_WIDTH      = 8,
    parameter int DSIZE                   = 16,
    parameter int AER_BIT_WIDTH           = 32,
    parameter int CONFIG_PARAMETER_NUMBER = 9
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic                                         cfg_mode_i,
    input  logic [AER_BIT_WIDTH-1:0]                     pkt_data_i,
    input  logic                                         pkt_valid_i,
    output logic                                         pkt_ready_o,
    output logic [DSIZE*2-1:0]                           config_data_o,
    output logic [CONFIG_PARAMETER_NUMBER-1:0]           config_write_enable_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                addr_config_a_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                addr_config_b_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] addr_config_c_o,
    output logic                                         ce_o,
    output logic                                         busy_o,
    output logic                                         load_done_o,
    output logic                                         load_err_o
);
    localparam int NW = NURN_CNT_BIT_WIDTH;
    localparam int AW = AXON_CNT_BIT_WIDTH;
    localparam int CW = NW + AW;
    localparam int DW = DSIZE * 2;
    localparam int TN = CONFIG_PARAMETER_NUMBER;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [3:0]      tgt_q, tgt_d;
    logic [7:0]      rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic [TN-1:0]   we_q, we_d;
    logic [NW-1:0]   addr_a_q, addr_a_d;
    logic [NW-1:0]   addr_b_q, addr_b_d;
    logic [CW-1:0]   addr_c_q, addr_c_d;
    logic            ce_q, ce_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept_s;
    logic [3:0]      hdr_tgt_s;
    logic [7:0]      hdr_cm1_s;
    logic [15:0]     hdr_addr_s;
    logic            hdr_ok_s;

    // The loader never holds back a word except while configuration mode is off.
    assign pkt_ready_o = cfg_mode_i;
    assign accept_s    = pkt_valid_i & cfg_mode_i;
    assign hdr_tgt_s   = pkt_data_i[AER_BIT_WIDTH-1 -: 4];
    assign hdr_cm1_s   = pkt_data_i[AER_BIT_WIDTH-5 -: 8];
    assign hdr_addr_s  = pkt_data_i[15:0];
    assign hdr_ok_s    = ({28'd0, hdr_tgt_s} < 32'(TN));

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_c_d = addr_c_q;
        err_d    = err_q;
        we_d     = {TN{1'b0}};
        ce_d     = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    tgt_d = hdr_tgt_s;
                    rem_d = hdr_cm1_s;
                    cnt_d = CW'(hdr_addr_s);
                    if (hdr_ok_s) begin
                        state_d = LOAD;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    data_d   = pkt_data_i[DW-1:0];
                    we_d     = {{(TN-1){1'b0}}, 1'b1} << tgt_q;
                    ce_d     = 1'b1;
                    addr_a_d = {NW{1'b0}};
                    addr_b_d = {NW{1'b0}};
                    addr_c_d = {CW{1'b0}};
                    case (tgt_q)
                        4'd0, 4'd8:             addr_a_d = cnt_q[NW-1:0];
                        4'd1, 4'd2:             addr_b_d = cnt_q[NW-1:0];
                        4'd3, 4'd4, 4'd5, 4'd6: addr_c_d = {cnt_q[NW-1:0], {AW{1'b0}}};
                        4'd7:                   addr_c_d = cnt_q;
                        default:                addr_c_d = {CW{1'b0}};
                    endcase
                    // The number register always lands at its single address.
                    if (tgt_q != 4'd8) begin
                        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (rem_q == 8'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            DRAIN: begin
                if (accept_s) begin
                    if (rem_q == 8'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            tgt_q    <= 4'd0;
            rem_q    <= 8'd0;
            cnt_q    <= {CW{1'b0}};
            data_q   <= {DW{1'b0}};
            we_q     <= {TN{1'b0}};
            addr_a_q <= {NW{1'b0}};
            addr_b_q <= {NW{1'b0}};
            addr_c_q <= {CW{1'b0}};
            ce_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            we_q     <= we_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            ce_q     <= ce_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign config_data_o         = data_q;
    assign config_write_enable_o = we_q;
    assign addr_config_a_o       = addr_a_q;
    assign addr_config_b_o       = addr_b_q;
    assign addr_config_c_o       = addr_c_q;
    assign ce_o                  = ce_q;
    assign load_done_o           = done_q;
    assign load_err_o            = err_q;
    assign busy_o                = (state_q != IDLE);

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: expected write events are queued as
// words are accepted and compared when strobes or done pulses appear.
module tb_config_loader;
    logic        clk;
    logic        rst_n;
    logic        cfg_mode;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] cfg_data;
    logic [8:0]  cfg_we;
    logic [7:0]  addr_a;
    logic [7:0]  addr_b;
    logic [15:0] addr_c;
    logic        ce;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0]  we;
        logic [31:0] data;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
        logic        done;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // model state
    logic [3:0]  m_t;
    logic [7:0]  m_rem;
    logic [15:0] m_cnt;
    logic        m_err;

    config_loader dut (
        .clk_i                 (clk),
        .rst_n_i               (rst_n),
        .cfg_mode_i            (cfg_mode),
        .pkt_data_i            (pkt_data),
        .pkt_valid_i           (pkt_valid),
        .pkt_ready_o           (pkt_ready),
        .config_data_o         (cfg_data),
        .config_write_enable_o (cfg_we),
        .addr_config_a_o       (addr_a),
        .addr_config_b_o       (addr_b),
        .addr_config_c_o       (addr_c),
        .ce_o                  (ce),
        .busy_o                (busy),
        .load_done_o           (done),
        .load_err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare every visible write or done event against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (cfg_we != 9'd0 || ce || done)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {20'd0, cfg_we, ce, done, err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("we", {23'd0, cfg_we}, {23'd0, e.we});
                chk("ce", {31'd0, ce}, {31'd0, (e.we != 9'd0)});
                chk("done", {31'd0, done}, {31'd0, e.done});
                chk("err", {31'd0, err}, {31'd0, e.err});
                if (e.we != 9'd0) begin
                    chk("data", cfg_data, e.data);
                    chk("addr_a", {24'd0, addr_a}, {24'd0, e.a});
                    chk("addr_b", {24'd0, addr_b}, {24'd0, e.b});
                    chk("addr_c", {16'd0, addr_c}, {16'd0, e.c});
                end
            end
        end
    end

    // Present one word; assumes cfg_mode is high so it is taken on the next edge.
    task automatic drive(input logic [31:0] w);
        pkt_valid = 1'b1;
        pkt_data  = w;
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
    endtask

    task automatic hdr(input logic [3:0] t, input logic [7:0] cm1, input logic [15:0] addr);
        m_t   = t;
        m_rem = cm1;
        m_cnt = addr;
        m_err = (t >= 4'd9);
        drive({t, cm1, 4'h0, addr});
    endtask

    task automatic pay(input logic [31:0] w);
        exp_t e;
        e.we = 9'd0; e.data = w; e.a = 8'd0; e.b = 8'd0; e.c = 16'd0;
        e.done = (m_rem == 8'd0);
        e.err  = m_err;
        if (m_t < 4'd9) begin
            e.we = 9'd1 << m_t;
            case (m_t)
                4'd0, 4'd8: e.a = m_cnt[7:0];
                4'd1, 4'd2: e.b = m_cnt[7:0];
                4'd7:       e.c = m_cnt;
                default:    e.c = {m_cnt[7:0], 8'h00};
            endcase
            if (m_t != 4'd8) m_cnt = m_cnt + 16'd1;
            sb.push_back(e);
        end else if (e.done) begin
            sb.push_back(e);
        end
        m_rem = m_rem - 8'd1;
        drive(w);
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 6 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cfg_mode = 1'b0; pkt_valid = 1'b0; pkt_data = 32'd0;
        m_t = 4'd0; m_rem = 8'd0; m_cnt = 16'd0; m_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", {23'd0, cfg_we}, 32'd0);
        chk("rst_outs", {24'd0, ce, busy, done, err, pkt_ready, 3'd0}, 32'd0);
        chk("rst_data", cfg_data, 32'd0);
        chk("rst_addr", {addr_a, addr_b, addr_c}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_mode = 1'b1;
        @(posedge clk);
        #1;

        // memA, back-to-back
        hdr(4'd0, 8'd2, 16'h0005);
        pay(32'h0000_000A); pay(32'h0000_000B); pay(32'h0000_000C);
        settle("memA");

        // neuron-address wrap on axon_mode target
        hdr(4'd3, 8'd1, 16'h00FF);
        pay(32'h3333_0001); pay(32'h3333_0002);
        settle("wrap");

        // weight bit, full-width carry
        hdr(4'd7, 8'd1, 16'h12FF);
        pay(32'h7777_0001); pay(32'h7777_0002);
        settle("weight");

        // bad target drains silently and sets the sticky error
        hdr(4'hF, 8'd1, 16'h0000);
        @(negedge clk);
        chk("bad_err", {31'd0, err}, 32'd1);
        chk("bad_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        pay(32'hDEAD_0001); pay(32'hDEAD_0002);
        settle("bad");
        chk("err_sticky", {31'd0, err}, 32'd1);
        hdr(4'd2, 8'd0, 16'h0030);
        pay(32'h0000_0077);
        settle("clear");
        chk("err_clear", {31'd0, err}, 32'd0);

        // pause mid-packet
        hdr(4'd1, 8'd2, 16'h0010);
        pay(32'h1111_0001);
        cfg_mode = 1'b0;
        pkt_valid = 1'b1;
        pkt_data = 32'h1111_0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pause_ready", {31'd0, pkt_ready}, 32'd0);
            if (i > 0) chk("pause_we", {23'd0, cfg_we}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("pause_busy", {31'd0, busy}, 32'd1);
        cfg_mode = 1'b1;
        pay(32'h1111_0002); pay(32'h1111_0003);
        settle("pause");

        // reset abort after the first of four words
        hdr(4'd0, 8'd3, 16'h0040);
        pay(32'h0000_00E1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_we", {23'd0, cfg_we}, 32'd0);
        chk("abort_outs", {27'd0, ce, busy, done, err, 1'b0}, 32'd0);
        chk("abort_addr", {addr_a, addr_b, addr_c}, 32'd0);
        chk("abort_data", cfg_data, 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        hdr(4'd4, 8'd0, 16'h0020);
        pay(32'h4444_0001);
        settle("fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1);
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Write-side sequencer for the per-core neuron configuration memory.
- Accepts configuration packets as a valid/ready stream of AER-width words: one header word, then N payload words.
- Turns each payload word into one write on the configuration memory's write port, driving data, a one-hot target write-enable, per-port addresses and ce.
- Sits between the NoC configuration unpacker and the configuration memory; active only in configuration mode.

Parameters:
- NURN_CNT_BIT_WIDTH, 8, neuron address width.
- AXON_CNT_BIT_WIDTH, 8, axon address width.
- DSIZE, 16, datapath width; write data is DSIZE*2 bits.
- AER_BIT_WIDTH, 32, packet word width; must be >= DSIZE*2.
- CONFIG_PARAMETER_NUMBER, 9, number of write targets, one write-enable bit each.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- cfg_mode_i  in  1  configuration mode; loader pauses when low
- pkt_data_i  in  AER_BIT_WIDTH  header/payload word
- pkt_valid_i  in  1  word valid
- pkt_ready_o  out  1  word accepted when valid & ready
- config_data_o  out  DSIZE*2  write data = pkt word[DSIZE*2-1:0]
- config_write_enable_o  out  CONFIG_PARAMETER_NUMBER  one-hot write strobe
- addr_config_a_o  out  NURN_CNT_BIT_WIDTH  neuron address, targets 0,8
- addr_config_b_o  out  NURN_CNT_BIT_WIDTH  neuron address, targets 1,2
- addr_config_c_o  out  NURN+AXON  {neuron,axon} address, targets 3-7
- ce_o  out  1  memory clock enable, high with any strobe
- busy_o  out  1  state != IDLE
- load_done_o  out  1  one-cycle pulse, packet completed
- load_err_o  out  1  sticky, bad target seen

Behaviour:
- Header fields:
  - [31:28] target T.
  - [27:20] count-1, giving 1..256 entries.
  - [19:16] reserved, ignored.
  - [15:0] start address ADDR.
- Target map:
  - 0 memA, 1 memB, 2 AER, 3-6 axon_mode_1..4, 7 weight learn-mode bit, 8 neuron/axon number register.
  - Any T >= CONFIG_PARAMETER_NUMBER is an error.
- FSM states are IDLE, LOAD and DRAIN. Reset state is IDLE.
- Reset values: all outputs 0, counter 0, load_err_o 0.
- pkt_ready_o = cfg_mode_i & (state != IDLE or no pending write); effectively cfg_mode_i in every state.
- Header handling:
  - In IDLE, an accepted word is the header. It latches T, remaining count and address counter.
  - Next state is LOAD if T is valid. Otherwise DRAIN and load_err_o is set.
  - A valid header clears load_err_o.
- Payload handling in LOAD (word accepted in cycle t):
  - In cycle t+1, registered outputs hold: config_data_o = word; config_write_enable_o = 1<<T; ce_o = 1; addresses from the counter value used for that word.
  - Strobe and ce_o drop in the following cycle unless another word was accepted.
  - Back-to-back words give contiguous strobes. config_data_o holds its last value when idle.
- Address formation:
  - Targets 0,8: addr_a = cnt[NURN-1:0].
  - Targets 1,2: addr_b = cnt[NURN-1:0].
  - Targets 3-6: addr_c = {cnt[NURN-1:0], AXON zeros}.
  - Target 7: addr_c = cnt[NURN+AXON-1:0].
  - Address outputs not selected by T hold 0.
- Counter increments by 1 per accepted payload word.
  - Wraps modulo 2^NURN for targets 0-6 (upper bits ignored).
  - Wraps modulo 2^(NURN+AXON) for target 7.
  - Target 8 writes the same address every time.
- Completion: on acceptance of the last payload word, the FSM returns to IDLE. load_done_o pulses in cycle t+1, coincident with the last strobe. A new header can be accepted in cycle t+1.
- DRAIN: consumes the remaining count words with no strobes and no ce_o. It then returns to IDLE and pulses load_done_o. load_err_o stays high.
- cfg_mode_i low mid-packet: ready drops and state, count and address freeze. Any already-registered strobe still completes. Loading resumes when cfg_mode_i returns high.
- Reset mid-packet: the packet is abandoned, the FSM goes to IDLE immediately, and all strobes clear asynchronously.
- pkt_valid_i high with ready low: no acceptance and no state change.

Test Plan:
- Load memA: header T=0, count-1=2, ADDR=0x0005, then words 0xA, 0xB, 0xC back-to-back. Expect strobe 9'b000000001 on 3 consecutive cycles, addr_a 5,6,7, data 0xA/0xB/0xC, load_done_o with the third strobe.
- Address wrap: T=3, ADDR=0x00FF, 2 words. Expect addr_c = 0xFF00 then 0x0000, enable bit 3.
- Weight bit: T=7, ADDR=0x12FF, 2 words. Expect addr_c = 0x12FF then 0x1300, enable bit 7.
- Bad target: T=0xF, count-1=1, 2 words. Expect 2 words accepted, no strobes or ce_o, load_err_o=1, done pulse. A following valid header (T=2) clears load_err_o.
- Pause: cfg_mode_i low for 4 cycles after the 1st of 3 payload words (T=1, ADDR=0x10). Expect ready low, no strobes during the pause, then addr_b 0x11,0x12 after resume.
- Reset abort: rst_n_i low after 1 of 4 words. Expect all outputs 0 and busy_o=0. A fresh packet then loads correctly.
